// File: rtl/timer_multi.sv
// timer_multi: NUM_CH independent one-shot / periodic timers sharing one
// programmable prescaler, each with a sticky interrupt and a registered irq.
//
// Ports:
//   clk                   rising-edge clock for all logic
//   reset                 synchronous, active-high; aborts every channel
//   prescale              a tick occurs every prescale+1 clk cycles
//   timer_count           terminal counts, channel i = [i*WIDTH +: WIDTH]
//   timer_enable          per-channel run enable (level)
//   timer_mode            per-channel mode: 0 one-shot, 1 periodic
//   timer_interrupt_clear per-channel pending clear (level)
//   timer_interrupt       per-channel sticky interrupt pending
//   timer_running         per-channel RUN state, registered
//   irq                   registered OR of the pending interrupts
module timer_multi #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [NUM_CH*WIDTH-1:0] timer_count,
    input  logic [NUM_CH-1:0]       timer_enable,
    input  logic [NUM_CH-1:0]       timer_mode,
    input  logic [NUM_CH-1:0]       timer_interrupt_clear,
    output logic [NUM_CH-1:0]       timer_interrupt,
    output logic [NUM_CH-1:0]       timer_running,
    output logic                    irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Shared prescaler
    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;
    logic                  tick;

    // Per-channel state
    state_e           state_q [NUM_CH];
    state_e           state_d [NUM_CH];
    logic [WIDTH-1:0] count_q [NUM_CH];
    logic [WIDTH-1:0] count_d [NUM_CH];

    logic [NUM_CH-1:0] intr_q;
    logic [NUM_CH-1:0] intr_d;
    logic [NUM_CH-1:0] run_q;
    logic [NUM_CH-1:0] run_d;
    logic [NUM_CH-1:0] expire;
    logic              irq_q;
    logic              irq_d;

    // >= rather than == so lowering prescale below the current phase
    // produces a tick immediately instead of wrapping the counter.
    always_comb begin
        tick   = (pcnt_q >= prescale);
        pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    end

    always_comb begin
        logic [WIDTH:0]   tc_eff;
        logic [WIDTH:0]   cnt_inc;
        logic [WIDTH-1:0] tc_raw;

        tc_eff  = '0;
        cnt_inc = '0;
        tc_raw  = '0;
        expire  = '0;
        intr_d  = '0;
        run_d   = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];

            tc_raw = timer_count[i*WIDTH +: WIDTH];
            // A terminal count of 0 behaves like 1: expire on every tick.
            if (tc_raw == '0) begin
                tc_eff = (WIDTH+1)'(1);
            end else begin
                tc_eff = {1'b0, tc_raw};
            end
            // One extra bit so tc = 2^WIDTH-1 compares without overflow.
            cnt_inc = {1'b0, count_q[i]} + (WIDTH+1)'(1);

            if (!timer_enable[i]) begin
                state_d[i] = ST_IDLE;
                count_d[i] = '0;
            end else begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        // The arming edge never counts a tick.
                        state_d[i] = ST_RUN;
                        count_d[i] = '0;
                    end
                    ST_RUN: begin
                        if (tick) begin
                            // >= so a tc lowered below count expires now.
                            if (cnt_inc >= tc_eff) begin
                                expire[i]  = 1'b1;
                                count_d[i] = '0;
                                state_d[i] = timer_mode[i] ? ST_RUN
                                                           : ST_DONE;
                            end else begin
                                count_d[i] = cnt_inc[WIDTH-1:0];
                            end
                        end
                    end
                    ST_DONE: begin
                        // Re-arming needs enable to drop first.
                        count_d[i] = '0;
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        count_d[i] = '0;
                    end
                endcase
            end

            run_d[i] = (state_d[i] == ST_RUN);

            // Set wins over a coincident clear; enable plays no part.
            intr_d[i] = expire[i]
                      | (intr_q[i] & ~timer_interrupt_clear[i]);
        end

        irq_d = |intr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
            intr_q <= '0;
            run_q  <= '0;
            irq_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                count_q[i] <= '0;
            end
        end else begin
            pcnt_q <= pcnt_d;
            intr_q <= intr_d;
            run_q  <= run_d;
            irq_q  <= irq_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    assign timer_interrupt = intr_q;
    assign timer_running   = run_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: vector table, directed corner sequences and a randomized
// run against a cycle-level behavioural model of the timer channels.
module tb_timer_multi;

    localparam int NC = 4;
    localparam int W  = 32;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [PW-1:0]   prescale;
    logic [NC*W-1:0] timer_count;
    logic [NC-1:0]   en;
    logic [NC-1:0]   mode;
    logic [NC-1:0]   clr;
    logic [NC-1:0]   intr;
    logic [NC-1:0]   running;
    logic            irq;

    int checks   = 0;
    int failures = 0;

    timer_multi #(
        .NUM_CH     (NC),
        .WIDTH      (W),
        .PRESCALE_W (PW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .prescale              (prescale),
        .timer_count           (timer_count),
        .timer_enable          (en),
        .timer_mode            (mode),
        .timer_interrupt_clear (clr),
        .timer_interrupt       (intr),
        .timer_running         (running),
        .irq                   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One rising edge; inputs are driven and outputs sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_tc(int ch, logic [W-1:0] v);
        timer_count[ch*W +: W] = v;
    endtask

    task automatic clear_inputs();
        en          = '0;
        mode        = '0;
        clr         = '0;
        timer_count = '0;
        prescale    = '0;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) cyc();
        reset = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    // A channel is described by: armed (enabled and past its arming edge),
    // finished (one-shot has fired), ticks (ticks counted toward the period).
    bit m_armed [NC];
    bit m_fin   [NC];
    int m_ticks [NC];
    bit m_intr  [NC];
    int k_edge;

    task automatic model_reset();
        k_edge = 0;
        for (int c = 0; c < NC; c++) begin
            m_armed[c] = 1'b0;
            m_fin[c]   = 1'b0;
            m_ticks[c] = 0;
            m_intr[c]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit tick;
        int tc;
        bit fire;
        k_edge++;
        // The prescaler starts at 0 after reset: tick on every (p+1)-th edge.
        tick = (k_edge % (int'(prescale) + 1)) == 0;
        for (int c = 0; c < NC; c++) begin
            tc   = int'(timer_count[c*W +: W]);
            tc   = (tc == 0) ? 1 : tc;
            fire = 1'b0;
            if (!en[c]) begin
                m_armed[c] = 1'b0;
                m_fin[c]   = 1'b0;
                m_ticks[c] = 0;
            end else if (!m_armed[c]) begin
                m_armed[c] = 1'b1;
                m_ticks[c] = 0;
            end else if (!m_fin[c] && tick) begin
                m_ticks[c] = m_ticks[c] + 1;
                if (m_ticks[c] >= tc) begin
                    fire       = 1'b1;
                    m_ticks[c] = 0;
                    m_fin[c]   = !mode[c];
                end
            end
            m_intr[c] = fire | (m_intr[c] & !clr[c]);
        end
    endtask

    function automatic logic [NC-1:0] m_intr_vec();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = m_intr[c];
        return v;
    endfunction

    function automatic logic [NC-1:0] m_run_vec();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = m_armed[c] & !m_fin[c];
        return v;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic         en;
        logic         mode;
        logic         clr;
        logic [W-1:0] tc;
        logic         e_intr;
        logic         e_run;
        logic         e_irq;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int n;

        reset = 1'b1;
        clear_inputs();

        // Channel 0 only, prescale 0.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'd3, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'd3, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'd1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'd1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'd1, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        do_reset(2);
        chk("reset_intr", 32'(intr), 32'h0);
        chk("reset_run", 32'(running), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);

        for (int i = 0; i < 12; i++) begin
            en[0]   = tbl[i].en;
            mode[0] = tbl[i].mode;
            clr[0]  = tbl[i].clr;
            set_tc(0, tbl[i].tc);
            cyc();
            chk($sformatf("vec%0d_intr", i), 32'(intr[0]), 32'(tbl[i].e_intr));
            chk($sformatf("vec%0d_run", i), 32'(running[0]), 32'(tbl[i].e_run));
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].e_irq));
        end

        // Reset held 3 cycles mid-run aborts everything.
        clear_inputs();
        do_reset(2);
        for (int c = 0; c < NC; c++) set_tc(c, 32'd5);
        mode = '1;
        en   = '1;
        repeat (3) cyc();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("rst%0d_intr", i), 32'(intr), 32'h0);
            chk($sformatf("rst%0d_run", i), 32'(running), 32'h0);
            chk($sformatf("rst%0d_irq", i), 32'(irq), 32'h0);
        end
        reset = 1'b0;
        repeat (5) cyc();
        chk("rst_after_e4_intr", 32'(intr), 32'h0);
        chk("rst_after_e4_run", 32'(running), 32'hf);
        cyc();
        chk("rst_after_e5_intr", 32'(intr), 32'hf);

        // One-shot latency, tc=10.
        clear_inputs();
        do_reset(2);
        set_tc(0, 32'd10);
        en[0] = 1'b1;
        repeat (10) cyc();
        chk("os_e9_intr", 32'(intr[0]), 32'h0);
        chk("os_e9_run", 32'(running[0]), 32'h1);
        cyc();
        chk("os_e10_intr", 32'(intr[0]), 32'h1);
        chk("os_e10_run", 32'(running[0]), 32'h0);
        chk("os_e10_irq", 32'(irq), 32'h1);
        clr[0] = 1'b1;
        cyc();
        clr[0] = 1'b0;
        repeat (20) cyc();
        chk("os_no_second", 32'(intr[0]), 32'h0);
        chk("os_stays_done", 32'(running[0]), 32'h0);

        // Periodic with prescale=3, tc=4: 16-cycle period.
        clear_inputs();
        do_reset(2);
        prescale = 8'd3;
        set_tc(1, 32'd4);
        mode[1] = 1'b1;
        en[1]   = 1'b1;
        n = 0;
        while (!intr[1] && n < 200) begin
            cyc();
            n++;
        end
        chk("per_first", 32'(intr[1]), 32'h1);
        clr[1] = 1'b1;
        repeat (15) cyc();
        chk("per_cleared", 32'(intr[1]), 32'h0);
        cyc();
        chk("per_set_wins", 32'(intr[1]), 32'h1);
        cyc();
        chk("per_clear_again", 32'(intr[1]), 32'h0);
        clr[1] = 1'b0;
        repeat (14) cyc();
        chk("per_before_next", 32'(intr[1]), 32'h0);
        cyc();
        chk("per_next", 32'(intr[1]), 32'h1);
        chk("per_running", 32'(running[1]), 32'h1);

        // tc=0 and tc=1 expire on every tick.
        clear_inputs();
        do_reset(2);
        set_tc(2, 32'd0);
        mode[2] = 1'b1;
        en[2]   = 1'b1;
        cyc();
        chk("tc0_arm", 32'(intr[2]), 32'h0);
        cyc();
        chk("tc0_first", 32'(intr[2]), 32'h1);
        clr[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("tc0_hold%0d", i), 32'(intr[2]), 32'h1);
        end
        set_tc(2, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("tc1_hold%0d", i), 32'(intr[2]), 32'h1);
        end
        en[2] = 1'b0;
        cyc();
        cyc();
        chk("tc1_cleared", 32'(intr[2]), 32'h0);
        clr[2] = 1'b0;

        // Lowering tc mid-run; disable keeps the pending flag.
        clear_inputs();
        do_reset(2);
        set_tc(3, 32'd100);
        en[3] = 1'b1;
        repeat (51) cyc();
        chk("low_cnt50", 32'(intr[3]), 32'h0);
        set_tc(3, 32'd20);
        cyc();
        chk("low_expire", 32'(intr[3]), 32'h1);
        chk("low_done", 32'(running[3]), 32'h0);
        en[3] = 1'b0;
        cyc();
        set_tc(3, 32'd100);
        en[3] = 1'b1;
        repeat (8) cyc();
        chk("dis_cnt7_run", 32'(running[3]), 32'h1);
        en[3] = 1'b0;
        cyc();
        chk("dis_idle", 32'(running[3]), 32'h0);
        chk("dis_retained", 32'(intr[3]), 32'h1);
        clr[3] = 1'b1;
        cyc();
        clr[3] = 1'b0;
        chk("dis_clear", 32'(intr[3]), 32'h0);
        set_tc(3, 32'd3);
        en[3] = 1'b1;
        repeat (3) cyc();
        chk("dis_rearm_e2", 32'(intr[3]), 32'h0);
        cyc();
        chk("dis_rearm_e3", 32'(intr[3]), 32'h1);

        // All channels expire on the same edge.
        clear_inputs();
        do_reset(2);
        for (int c = 0; c < NC; c++) set_tc(c, 32'd8);
        en = '1;
        repeat (8) cyc();
        chk("all_e7", 32'(intr), 32'h0);
        cyc();
        chk("all_e8", 32'(intr), 32'hf);
        chk("all_irq", 32'(irq), 32'h1);
        for (int c = 0; c < NC; c++) begin
            clr = NC'(1) << c;
            cyc();
            clr = '0;
            chk($sformatf("all_clr%0d_irq", c), 32'(irq),
                (c < NC - 1) ? 32'h1 : 32'h0);
        end

        // Randomized run against the model.
        clear_inputs();
        prescale = PW'($urandom_range(0, 3));
        do_reset(2);
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 31) == 0) mode[c] = ~mode[c];
                if ($urandom_range(0, 23) == 0)
                    set_tc(c, W'($urandom_range(0, 6)));
                clr[c] = ($urandom_range(0, 3) == 0);
            end
            model_edge();
            cyc();
            chk($sformatf("rnd%0d_intr", i), 32'(intr), 32'(m_intr_vec()));
            chk($sformatf("rnd%0d_run", i), 32'(running), 32'(m_run_vec()));
            chk($sformatf("rnd%0d_irq", i), 32'(irq), 32'(|m_intr_vec()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
